// File: rtl/prog_loader.sv
// Boot-time program loader: decodes SYNC/ADDR/LEN/DATA/CSUM frames from a host byte
// stream, writes the payload into CPU RAM and holds the CPU in reset until a good frame lands.
module prog_loader #(
    parameter int          ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic              err_timeout
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;

    logic              mem_we_d, cpu_reset_d, load_done_d, load_err_d, err_timeout_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;

    logic       accept;
    logic [7:0] sum;

    assign accept = s_valid && s_ready;
    assign sum    = csum_q + s_data;
    assign busy   = (state_q != S_IDLE);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        tcnt_d        = tcnt_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        cpu_reset_d   = cpu_reset;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;
        err_timeout_d = err_timeout;

        // Idle-gap watchdog; an accepted byte and an expiry are mutually exclusive.
        if (state_q != S_IDLE) begin
            if (accept) begin
                tcnt_d = '0;
            end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TO_LAST) begin
                tcnt_d        = '0;
                load_err_d    = 1'b1;
                err_timeout_d = 1'b1;
                state_d       = S_IDLE;
            end else begin
                tcnt_d = tcnt_q + TO_W'(1);
            end
        end

        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (s_data == SYNC_BYTE) begin
                        csum_d      = '0;
                        tcnt_d      = '0;
                        cpu_reset_d = 1'b1;
                        state_d     = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = ADDR_W'(s_data);
                    csum_d  = sum;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d   = (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
                    csum_d  = sum;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = s_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    csum_d      = sum;
                    cnt_d       = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (sum == 8'd0) begin
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        load_err_d    = 1'b1;
                        err_timeout_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            tcnt_q      <= '0;
            s_ready     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_reset   <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            tcnt_q      <= tcnt_d;
            s_ready     <= 1'b1;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            cpu_reset   <= cpu_reset_d;
            load_done   <= load_done_d;
            load_err    <= load_err_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus random
// frames, checked against expectations derived from the frame format and checksum rule.
module tb_prog_loader;

    localparam int         TO   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] wr_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, mem_we, cpu_reset, busy, load_done, load_err, err_timeout;
    logic [7:0] mem_addr, mem_wdata;

    prog_loader #(
        .ADDR_W        (8),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    wr_q_t wr_q;
    int    wr_cyc[$];
    int    cyc = 0;
    int    done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic  done_cpu_rst = 1'b1, last_to = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
        if (load_done) begin
            done_cnt++;
            done_cpu_rst = cpu_reset;
        end
        if (load_err) begin
            err_cnt++;
            last_to = err_timeout;
        end
        if (load_done && load_err) both_cnt++;
    end

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    // Presents one byte for exactly one clock edge, after an optional idle gap.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    function automatic logic [7:0] csum_for(input logic [7:0] addr, input logic [7:0] len_b,
                                            input byte_q_t d);
        int s;
        s = int'(addr) + int'(len_b);
        foreach (d[i]) s += int'(d[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Builds SYNC,ADDR,LEN,data...,CSUM plus the RAM writes the frame should cause.
    task automatic make_frame(input logic [7:0] addr, input byte_q_t d, input bit good,
                              output byte_q_t fr, output wr_q_t ex);
        logic [7:0] lb, c;
        lb = 8'(d.size() % 256);
        c  = csum_for(addr, lb, d);
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        fr = {SYNC, addr, lb};
        ex = {};
        foreach (d[i]) begin
            fr.push_back(d[i]);
            ex.push_back({8'((int'(addr) + i) % 256), d[i]});
        end
        fr.push_back(c);
    endtask

    task automatic run_frame(input string tag, input byte_q_t fr, input wr_q_t ex,
                             input bit good, input bit gapless);
        int w;
        bit consec;
        clear_mon();
        foreach (fr[i]) send_byte(fr[i], gapless ? 0 : int'($urandom_range(0, 2)));
        w = 0;
        while (done_cnt + err_cnt == 0 && w < 8) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        check({tag, " nwrites"}, wr_q.size(), ex.size());
        for (int i = 0; i < ex.size() && i < wr_q.size(); i++)
            check($sformatf("%s write%0d addr_data", tag, i), wr_q[i], ex[i]);
        check({tag, " done_pulses"}, done_cnt, good ? 1 : 0);
        check({tag, " err_pulses"}, err_cnt, good ? 0 : 1);
        check({tag, " done_and_err"}, both_cnt, 0);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " cpu_reset_after"}, cpu_reset, good ? 0 : 1);
        if (good) check({tag, " cpu_reset_at_done"}, done_cpu_rst, 0);
        else      check({tag, " err_timeout_flag"}, last_to, 0);
        if (gapless && ex.size() > 1) begin
            consec = 1'b1;
            for (int i = 1; i < wr_cyc.size(); i++)
                if (wr_cyc[i] - wr_cyc[i-1] != 1) consec = 1'b0;
            check({tag, " writes_back_to_back"}, consec, 1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " s_ready"}, s_ready, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " cpu_reset"}, cpu_reset, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " load_done"}, load_done, 0);
        check({tag, " load_err"}, load_err, 0);
        check({tag, " err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t fr, d;
        wr_q_t   ex;
        int      fire_n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("s_ready_after_reset", s_ready, 1);

        // Good load, exact test-plan bytes.
        fr = {SYNC, 8'h00, 8'h03, 8'h01, 8'h0A, 8'h03, 8'hEF};
        ex = {16'h0001, 16'h010A, 16'h0203};
        run_frame("good", fr, ex, 1, 1);

        // Bad checksum: writes still happen.
        fr = {SYNC, 8'h00, 8'h03, 8'h01, 8'h0A, 8'h03, 8'hEE};
        run_frame("badsum", fr, ex, 0, 1);

        // Address wrap FE, FF, 00.
        d = {8'h11, 8'h22, 8'h33};
        make_frame(8'hFE, d, 1, fr, ex);
        check("wrap expected_last_addr", ex[2][15:8], 8'h00);
        run_frame("wrap", fr, ex, 1, 1);

        // Garbage before a frame is ignored.
        clear_mon();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        @(negedge clk);
        check("garbage busy", busy, 0);
        check("garbage nwrites", wr_q.size(), 0);
        @(posedge clk); #1;
        d = {8'h7E};
        make_frame(8'h10, d, 1, fr, ex);
        run_frame("after_garbage", fr, ex, 1, 1);

        // A new SYNC after a good load reasserts cpu_reset; SYNC inside data is plain data.
        send_byte(SYNC, 0);
        check("resync cpu_reset", cpu_reset, 1);
        check("resync busy", busy, 1);
        d = {SYNC, SYNC};
        make_frame(8'h40, d, 1, fr, ex);
        void'(fr.pop_front());
        run_frame("sync_in_data", fr, ex, 1, 1);

        // Timeout after SYNC,ADDR with the link gone quiet.
        clear_mon();
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        fire_n = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (load_err) begin
                fire_n = n;
                break;
            end
        end
        check("timeout fired_in_window", (fire_n >= TO && fire_n <= TO + 1) ? 1 : 0, 1);
        check("timeout err_timeout", err_timeout, 1);
        check("timeout busy", busy, 0);
        check("timeout cpu_reset", cpu_reset, 1);
        repeat (2) @(negedge clk);
        check("timeout err_pulses", err_cnt, 1);
        check("timeout done_pulses", done_cnt, 0);
        @(posedge clk); #1;
        d = {8'h5C, 8'hC5};
        make_frame(8'h80, d, 1, fr, ex);
        run_frame("after_timeout", fr, ex, 1, 0);
        check("err_timeout_holds", err_timeout, 1);

        // Reset mid-frame, with a data byte offered during the reset cycle.
        clear_mon();
        fr = {SYNC, 8'h20, 8'h04, 8'hAA, 8'hBB};
        foreach (fr[i]) send_byte(fr[i], 0);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hCC;
        @(posedge clk); #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        check_reset_values("midreset");
        repeat (3) @(posedge clk); #1;
        check("midreset nwrites", wr_q.size(), 2);
        if (wr_q.size() == 2) check("midreset last_write", wr_q[1], 16'h21BB);
        check("midreset pulses", done_cnt + err_cnt, 0);
        d = {8'h01, 8'h02, 8'h03, 8'h04};
        make_frame(8'h20, d, 1, fr, ex);
        run_frame("after_midreset", fr, ex, 1, 1);

        // Random frames: random address/length/data, some corrupted, garbage prefixes, gaps.
        for (int k = 0; k < 15; k++) begin
            int         len;
            bit         good;
            logic [7:0] b;
            len  = (k == 0) ? 256 : int'($urandom_range(1, 12));
            good = ($urandom_range(0, 3) != 0);
            d = {};
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            make_frame(8'($urandom), d, good, fr, ex);
            repeat ($urandom_range(0, 3)) begin
                do b = 8'($urandom); while (b == SYNC);
                fr.push_front(b);
            end
            run_frame($sformatf("rnd%0d", k), fr, ex, good, k < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
